// File: rtl/zsram_array.sv
// zsram_array: DEPTH x WIDTH scratch RAM with these features:
//   - per-bit write mask
//   - registered read pipeline, 1 or 2 cycles deep
//   - write-first bypass when a read and a write hit the same address in one cycle
//   - init sweep that loads INIT_VALUE into every word after reset or on ClearRequest
//
// Ports:
//   Crystal50Mhz             clock, rising edge
//   ResetN                   asynchronous active-low reset
//   WriteEdge/WriteAddress   write strobe and word address
//   inputData/WriteMask      write data; a mask bit of 1 writes that data bit
//   ReadEdge/ReadAddress     read strobe and word address
//   outputData/outputValid   read result; it holds between reads; valid is a 1-cycle pulse
//   ClearRequest             restarts the init sweep (only honoured when idle)
//   Busy                     high while the sweep runs; all strobes are dropped then
module zsram_array #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      DEPTH        = 16,
    parameter int unsigned      AW           = 4,
    parameter int unsigned      READ_LATENCY = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic             Crystal50Mhz,
    input  logic             ResetN,
    input  logic             WriteEdge,
    input  logic [AW-1:0]    WriteAddress,
    input  logic [WIDTH-1:0] inputData,
    input  logic [WIDTH-1:0] WriteMask,
    input  logic             ReadEdge,
    input  logic [AW-1:0]    ReadAddress,
    output logic [WIDTH-1:0] outputData,
    output logic             outputValid,
    input  logic             ClearRequest,
    output logic             Busy
);

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    sweep_ptr_q, sweep_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             ready;
    logic             wr_in_range, rd_in_range;
    logic             wr_fire, rd_fire;
    logic [WIDTH-1:0] wr_merged;
    logic [WIDTH-1:0] rd_word;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             stage_valid;
    logic [WIDTH-1:0] stage_data;

    assign ready       = (state_q == ST_READY);
    assign wr_in_range = ({1'b0, WriteAddress} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, ReadAddress} < DEPTH_EXT);
    assign wr_fire     = ready & WriteEdge & wr_in_range;
    assign rd_fire     = ready & ReadEdge;

    // The merged word is the value the write will store.
    // A same-address read in the same cycle returns it (write-first).
    always_comb begin
        wr_merged = '0;
        if (wr_in_range) begin
            wr_merged = (mem[WriteAddress] & ~WriteMask) | (inputData & WriteMask);
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (wr_fire && (WriteAddress == ReadAddress)) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[ReadAddress];
            end
        end
    end

    // The array has a single write port, shared by the sweep and by user writes.
    // While reset is held, the port keeps rewriting word 0 with INIT_VALUE.
    // That is harmless, because the sweep overwrites word 0 first.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = WriteAddress;
        mem_wdata = wr_merged;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_ptr_q;
            mem_wdata = INIT_VALUE;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge Crystal50Mhz) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (sweep_ptr_q == LAST_PTR) begin
                    state_d     = ST_READY;
                    sweep_ptr_d = '0;
                end else begin
                    sweep_ptr_d = sweep_ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                if (ClearRequest) begin
                    state_d     = ST_CLEAR;
                    sweep_ptr_d = '0;
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                sweep_ptr_d = '0;
            end
        endcase
    end

    // The second read stage does not depend on the FSM state.
    // A read sampled just before a clear therefore still completes.
    if (READ_LATENCY == 2) begin : g_lat2
        logic             s1_valid_q, s1_valid_d;
        logic [WIDTH-1:0] s1_data_q, s1_data_d;

        always_comb begin
            s1_valid_d = rd_fire;
            s1_data_d  = rd_word;
        end

        always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
            if (!ResetN) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_data_q  <= s1_data_d;
            end
        end

        assign stage_valid = s1_valid_q;
        assign stage_data  = s1_data_q;
    end else begin : g_lat1
        assign stage_valid = rd_fire;
        assign stage_data  = rd_word;
    end

    always_comb begin
        out_valid_d = stage_valid;
        out_data_d  = out_data_q;
        if (stage_valid) begin
            out_data_d = stage_data;
        end
    end

    always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= ST_CLEAR;
            sweep_ptr_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign outputData  = out_data_q;
    assign outputValid = out_valid_q;
    assign Busy        = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_zsram_array.sv
// Directed bench for zsram_array. Two instances are driven with the same stimulus.
//   u_a: DEPTH=16, READ_LATENCY=1, INIT_VALUE=8'hA5
//   u_b: DEPTH=10, READ_LATENCY=2, INIT_VALUE=8'h00
// Every expected value below is a constant worked out by hand from the operation history.
module tb_zsram_array;

    logic       clk;
    logic       rst_n;
    logic       wr_edge;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] wr_mask;
    logic       rd_edge;
    logic [3:0] rd_addr;
    logic       clr_req;

    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       busy_a, busy_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_a_tbl [16];
    logic [7:0] exp_b_tbl [16];

    zsram_array #(
        .WIDTH(8), .DEPTH(16), .AW(4), .READ_LATENCY(1), .INIT_VALUE(8'hA5)
    ) u_a (
        .Crystal50Mhz(clk), .ResetN(rst_n),
        .WriteEdge(wr_edge), .WriteAddress(wr_addr), .inputData(wr_data), .WriteMask(wr_mask),
        .ReadEdge(rd_edge), .ReadAddress(rd_addr),
        .outputData(data_a), .outputValid(valid_a),
        .ClearRequest(clr_req), .Busy(busy_a)
    );

    zsram_array #(
        .WIDTH(8), .DEPTH(10), .AW(4), .READ_LATENCY(2), .INIT_VALUE(8'h00)
    ) u_b (
        .Crystal50Mhz(clk), .ResetN(rst_n),
        .WriteEdge(wr_edge), .WriteAddress(wr_addr), .inputData(wr_data), .WriteMask(wr_mask),
        .ReadEdge(rd_edge), .ReadAddress(rd_addr),
        .outputData(data_b), .outputValid(valid_b),
        .ClearRequest(clr_req), .Busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_edge = 1'b0;
        rd_edge = 1'b0;
        clr_req = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
        wr_mask = '0;
    endtask

    // Counts clock edges from now until Busy falls on each instance (bounded).
    task automatic measure_busy(input string name, input int exp_a, input int exp_b);
        int na = 0;
        int nb = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!busy_a && na == 0) na = i;
            if (!busy_b && nb == 0) nb = i;
            if (na != 0 && nb != 0) break;
        end
        vectors++;
        if (na !== exp_a) begin
            miscompares++;
            $display("FAIL %s_len_a: got %0d cycles expected %0d", name, na, exp_a);
        end
        vectors++;
        if (nb !== exp_b) begin
            miscompares++;
            $display("FAIL %s_len_b: got %0d cycles expected %0d", name, nb, exp_b);
        end
    endtask

    // Reads addresses 0..15 back to back and checks the results against exp_*_tbl.
    task automatic test_read_sweep(input string name);
        for (int i = 0; i <= 16; i++) begin
            rd_edge = (i < 16);
            rd_addr = 4'(i);
            step();
            if (i < 16) begin
                vectors++;
                if (valid_a !== 1'b1 || data_a !== exp_a_tbl[i]) begin
                    miscompares++;
                    $display("FAIL %s_a[%0d]: got v=%b d=%h expected v=1 d=%h", name, i, valid_a, data_a, exp_a_tbl[i]);
                end
            end else begin
                vectors++;
                if (valid_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_a_tail: got v=%b expected v=0", name, valid_a);
                end
            end
            if (i >= 1) begin
                vectors++;
                if (valid_b !== 1'b1 || data_b !== exp_b_tbl[i-1]) begin
                    miscompares++;
                    $display("FAIL %s_b[%0d]: got v=%b d=%h expected v=1 d=%h", name, i-1, valid_b, data_b, exp_b_tbl[i-1]);
                end
            end
        end
        rd_edge = 1'b0;
        step();
        vectors++;
        if (valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_b_tail: got v=%b expected v=0", name, valid_b);
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: got %b/%b expected 1/1", busy_a, busy_b);
        end
        vectors++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b/%b expected 0/0", valid_a, valid_b);
        end
        vectors++;
        if (data_a !== 8'h00 || data_b !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h expected 00/00", data_a, data_b);
        end
        rst_n = 1'b1;
        measure_busy("reset_sweep", 16, 10);
        for (int i = 0; i < 16; i++) begin
            exp_a_tbl[i] = 8'hA5;
            exp_b_tbl[i] = 8'h00;
        end
        test_read_sweep("init_read");
    endtask

    task automatic test_masked_write();
        wr_edge = 1'b1; wr_addr = 4'd3; wr_data = 8'hFF; wr_mask = 8'h0F;
        step();
        idle();
        rd_edge = 1'b1; rd_addr = 4'd3;
        step();
        rd_edge = 1'b0;
        vectors++;
        if (valid_a !== 1'b1 || data_a !== 8'hAF) begin
            miscompares++;
            $display("FAIL mask_a: got v=%b d=%h expected v=1 d=af", valid_a, data_a);
        end
        vectors++;
        if (valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_b_early: got v=%b expected v=0", valid_b);
        end
        step();
        vectors++;
        if (valid_a !== 1'b0 || data_a !== 8'hAF) begin
            miscompares++;
            $display("FAIL mask_a_hold: got v=%b d=%h expected v=0 d=af", valid_a, data_a);
        end
        vectors++;
        if (valid_b !== 1'b1 || data_b !== 8'h0F) begin
            miscompares++;
            $display("FAIL mask_b: got v=%b d=%h expected v=1 d=0f", valid_b, data_b);
        end
        // An all-zero mask must leave the word untouched.
        wr_edge = 1'b1; wr_addr = 4'd3; wr_data = 8'h00; wr_mask = 8'h00;
        step();
        idle();
        rd_edge = 1'b1; rd_addr = 4'd3;
        step();
        rd_edge = 1'b0;
        vectors++;
        if (data_a !== 8'hAF) begin
            miscompares++;
            $display("FAIL mask0_a: got %h expected af", data_a);
        end
        step();
        vectors++;
        if (data_b !== 8'h0F) begin
            miscompares++;
            $display("FAIL mask0_b: got %h expected 0f", data_b);
        end
    endtask

    task automatic test_bypass();
        wr_edge = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; wr_mask = 8'hFF;
        rd_edge = 1'b1; rd_addr = 4'd5;
        step();
        // The next write to the same word must not disturb the read already in flight in u_b.
        rd_edge = 1'b0;
        wr_data = 8'h11;
        vectors++;
        if (valid_a !== 1'b1 || data_a !== 8'h3C) begin
            miscompares++;
            $display("FAIL bypass_a: got v=%b d=%h expected v=1 d=3c", valid_a, data_a);
        end
        step();
        idle();
        vectors++;
        if (valid_b !== 1'b1 || data_b !== 8'h3C) begin
            miscompares++;
            $display("FAIL bypass_b: got v=%b d=%h expected v=1 d=3c", valid_b, data_b);
        end
        wr_edge = 1'b1; wr_addr = 4'd6; wr_data = 8'hFF; wr_mask = 8'hF0;
        rd_edge = 1'b1; rd_addr = 4'd6;
        step();
        idle();
        vectors++;
        if (data_a !== 8'hF5) begin
            miscompares++;
            $display("FAIL bypass_part_a: got %h expected f5", data_a);
        end
        step();
        vectors++;
        if (data_b !== 8'hF0) begin
            miscompares++;
            $display("FAIL bypass_part_b: got %h expected f0", data_b);
        end
        rd_edge = 1'b1; rd_addr = 4'd5;
        step();
        rd_edge = 1'b0;
        vectors++;
        if (data_a !== 8'h11) begin
            miscompares++;
            $display("FAIL later_write_a: got %h expected 11", data_a);
        end
        step();
        vectors++;
        if (data_b !== 8'h11) begin
            miscompares++;
            $display("FAIL later_write_b: got %h expected 11", data_b);
        end
    endtask

    task automatic test_out_of_range();
        wr_edge = 1'b1; wr_addr = 4'd12; wr_data = 8'h77; wr_mask = 8'hFF;
        step();
        idle();
        rd_edge = 1'b1; rd_addr = 4'd12;
        step();
        rd_edge = 1'b0;
        vectors++;
        if (valid_a !== 1'b1 || data_a !== 8'h77) begin
            miscompares++;
            $display("FAIL oor_in_range_a: got v=%b d=%h expected v=1 d=77", valid_a, data_a);
        end
        step();
        vectors++;
        if (valid_b !== 1'b1 || data_b !== 8'h00) begin
            miscompares++;
            $display("FAIL oor_read_b: got v=%b d=%h expected v=1 d=00", valid_b, data_b);
        end
        for (int i = 0; i < 16; i++) begin
            exp_a_tbl[i] = 8'hA5;
            exp_b_tbl[i] = 8'h00;
        end
        exp_a_tbl[3] = 8'hAF; exp_a_tbl[5] = 8'h11; exp_a_tbl[6] = 8'hF5; exp_a_tbl[12] = 8'h77;
        exp_b_tbl[3] = 8'h0F; exp_b_tbl[5] = 8'h11; exp_b_tbl[6] = 8'hF0;
        test_read_sweep("oor_contents");
    endtask

    task automatic test_clear();
        rd_edge = 1'b1; rd_addr = 4'd3; clr_req = 1'b1;
        step();
        vectors++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_busy: got %b/%b expected 1/1", busy_a, busy_b);
        end
        vectors++;
        if (valid_a !== 1'b1 || data_a !== 8'hAF) begin
            miscompares++;
            $display("FAIL clear_same_edge_a: got v=%b d=%h expected v=1 d=af", valid_a, data_a);
        end
        // Strobes issued while busy, and a repeated ClearRequest, must all be dropped.
        rd_addr = 4'd5;
        wr_edge = 1'b1; wr_addr = 4'd6; wr_data = 8'h00; wr_mask = 8'hFF;
        step();
        vectors++;
        if (valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_ignored_a: got v=%b expected v=0", valid_a);
        end
        vectors++;
        if (valid_b !== 1'b1 || data_b !== 8'h0F) begin
            miscompares++;
            $display("FAIL clear_inflight_b: got v=%b d=%h expected v=1 d=0f", valid_b, data_b);
        end
        step();
        vectors++;
        if (valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_ignored_b: got v=%b expected v=0", valid_b);
        end
        idle();
        measure_busy("clear_sweep", 14, 8);
        for (int i = 0; i < 16; i++) begin
            exp_a_tbl[i] = 8'hA5;
            exp_b_tbl[i] = 8'h00;
        end
        test_read_sweep("after_clear");
    endtask

    task automatic test_mid_reset();
        // Reset arriving while a read is pending: u_b loses its second-stage result.
        wr_edge = 1'b1; wr_addr = 4'd2; wr_data = 8'h3C; wr_mask = 8'hFF;
        step();
        idle();
        rd_edge = 1'b1; rd_addr = 4'd2;
        step();
        rd_edge = 1'b0;
        vectors++;
        if (valid_a !== 1'b1 || data_a !== 8'h3C) begin
            miscompares++;
            $display("FAIL pre_reset_a: got v=%b d=%h expected v=1 d=3c", valid_a, data_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (valid_a !== 1'b0 || data_a !== 8'h00 || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_a: got v=%b d=%h busy=%b expected v=0 d=00 busy=1", valid_a, data_a, busy_a);
        end
        step();
        vectors++;
        if (valid_b !== 1'b0 || data_b !== 8'h00 || busy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL pending_lost_b: got v=%b d=%h busy=%b expected v=0 d=00 busy=1", valid_b, data_b, busy_b);
        end
        rst_n = 1'b1;
        measure_busy("reset_read", 16, 10);

        // Reset arriving mid-sweep, with SweepPtr at 7.
        clr_req = 1'b1; rd_edge = 1'b1; rd_addr = 4'd0;
        step();
        idle();
        repeat (7) step();
        vectors++;
        if (busy_a !== 1'b1 || data_a !== 8'hA5) begin
            miscompares++;
            $display("FAIL mid_sweep_a: got busy=%b d=%h expected busy=1 d=a5", busy_a, data_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (data_a !== 8'h00 || valid_a !== 1'b0 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_sweep_reset: got d=%h v=%b busy=%b/%b expected d=00 v=0 busy=1/1", data_a, valid_a, busy_a, busy_b);
        end
        step();
        rst_n = 1'b1;
        measure_busy("restart_sweep", 16, 10);
        for (int i = 0; i < 16; i++) begin
            exp_a_tbl[i] = 8'hA5;
            exp_b_tbl[i] = 8'h00;
        end
        test_read_sweep("after_restart");
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_masked_write();
        test_bypass();
        test_out_of_range();
        test_clear();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
